// File: rtl/ddr5_device_responder.sv
// DDR5 device-side command responder: decodes two-phase CA commands, tracks
// per-bank open rows and drives a single outstanding 16-beat burst to a backing store.
module ddr5_device_responder #(
    parameter int DATA_WIDTH = 16,
    parameter int RL         = 11,
    parameter int WL         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_n,
    input  logic [13:0]           ca,
    input  logic [DATA_WIDTH-1:0] dq_in,
    output logic [DATA_WIDTH-1:0] dq_out,
    output logic                  dq_oe,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [29:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  protocol_err,
    output logic [2:0]            err_code
);

    typedef enum logic [1:0] {PH_CMD, PH_ACT, PH_RD, PH_WR} phase_t;
    typedef enum logic [1:0] {BS_IDLE, BS_WAIT, BS_XFER, BS_TAIL} burst_t;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL     = 3'd1;
    localparam logic [2:0] ERR_BANK_IDLE   = 3'd2;
    localparam logic [2:0] ERR_BANK_ACTIVE = 3'd3;
    localparam logic [2:0] ERR_REF_OPEN    = 3'd4;
    localparam logic [2:0] ERR_BUSY        = 3'd5;
    localparam logic [2:0] ERR_CS_SEQ      = 3'd6;

    // Delay loaded at phase-2 so that the first beat is emitted RL-1 (read) or WL (write) edges later.
    localparam logic [7:0] RD_LOAD = 8'(RL - 2);
    localparam logic [7:0] WR_LOAD = 8'(WL - 1);

    phase_t ph_r, ph_s;
    burst_t bs_r, bs_s;

    logic [9:2]  p1_ca_r;
    logic [3:0]  p1_bank_s;
    logic [15:0] bank_act_r;
    logic [15:0] bank_row_r [16];

    logic [7:0]  dly_r;
    logic [3:0]  beat_r;
    logic        burst_rd_r;
    logic [3:0]  burst_bank_r;
    logic [15:0] burst_row_r;
    logic [5:0]  burst_col_r;
    logic        burst_ap_n_r;

    logic [2:0]  err_code_s;
    logic        act_go_s;
    logic        burst_go_s;
    logic        pre_go_s;
    logic        emit_s;

    logic                  dq_oe_r;
    logic                  mem_rd_en_r;
    logic                  mem_wr_en_r;
    logic [29:0]           mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wr_data_r;
    logic                  protocol_err_r;
    logic [2:0]            err_code_r;

    logic unused_ca_s;
    assign unused_ca_s = ^ca[13:12];

    assign p1_bank_s = p1_ca_r[9:6];

    // Command phase register and burst engine state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_r <= PH_CMD;
            bs_r <= BS_IDLE;
        end else begin
            ph_r <= ph_s;
            bs_r <= bs_s;
        end
    end

    // Command decode: phase tracking, bank-state legality and error classification.
    always_comb begin
        ph_s       = PH_CMD;
        err_code_s = ERR_NONE;
        act_go_s   = 1'b0;
        burst_go_s = 1'b0;
        pre_go_s   = 1'b0;
        case (ph_r)
            PH_CMD: begin
                if (cs_n) begin
                    ph_s = PH_CMD;
                end else if (ca[1:0] == 2'b00) begin
                    ph_s = PH_ACT;
                end else if (ca[4:0] == 5'b11101) begin
                    ph_s = PH_RD;
                end else if (ca[4:0] == 5'b01101) begin
                    ph_s = PH_WR;
                end else if (ca[5:0] == 6'b011011) begin
                    pre_go_s = 1'b1;
                end else if (ca[4:0] == 5'b10011) begin
                    if (|bank_act_r) begin
                        err_code_s = ERR_REF_OPEN;
                    end else begin
                        err_code_s = ERR_NONE;
                    end
                end else begin
                    err_code_s = ERR_ILLEGAL;
                end
            end
            PH_ACT: begin
                if (!cs_n) begin
                    err_code_s = ERR_CS_SEQ;
                end else if (bank_act_r[p1_bank_s]) begin
                    err_code_s = ERR_BANK_ACTIVE;
                end else begin
                    act_go_s = 1'b1;
                end
            end
            PH_RD, PH_WR: begin
                if (!cs_n) begin
                    err_code_s = ERR_CS_SEQ;
                end else if (!bank_act_r[p1_bank_s]) begin
                    err_code_s = ERR_BANK_IDLE;
                end else if (bs_r != BS_IDLE) begin
                    err_code_s = ERR_BUSY;
                end else begin
                    burst_go_s = 1'b1;
                end
            end
            default: ph_s = PH_CMD;
        endcase
    end

    // Burst sequencing; the tail state gives auto-precharge its cycle after the last beat.
    always_comb begin
        bs_s   = bs_r;
        emit_s = 1'b0;
        case (bs_r)
            BS_IDLE: begin
                if (burst_go_s) begin
                    bs_s = BS_WAIT;
                end else begin
                    bs_s = BS_IDLE;
                end
            end
            BS_WAIT: begin
                if (dly_r == 8'd0) begin
                    emit_s = 1'b1;
                    bs_s   = BS_XFER;
                end else begin
                    bs_s = BS_WAIT;
                end
            end
            BS_XFER: begin
                emit_s = 1'b1;
                if (beat_r == 4'd15) begin
                    bs_s = BS_TAIL;
                end else begin
                    bs_s = BS_XFER;
                end
            end
            BS_TAIL: bs_s = BS_IDLE;
            default: bs_s = BS_IDLE;
        endcase
    end

    // Bank table, burst context and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1_ca_r        <= 8'd0;
            bank_act_r     <= 16'd0;
            for (int i = 0; i < 16; i++) begin
                bank_row_r[i] <= 16'd0;
            end
            dly_r          <= 8'd0;
            beat_r         <= 4'd0;
            burst_rd_r     <= 1'b0;
            burst_bank_r   <= 4'd0;
            burst_row_r    <= 16'd0;
            burst_col_r    <= 6'd0;
            burst_ap_n_r   <= 1'b1;
            dq_oe_r        <= 1'b0;
            mem_rd_en_r    <= 1'b0;
            mem_wr_en_r    <= 1'b0;
            mem_addr_r     <= 30'd0;
            mem_wr_data_r  <= {DATA_WIDTH{1'b0}};
            protocol_err_r <= 1'b0;
            err_code_r     <= 3'd0;
        end else begin
            if (ph_s != PH_CMD) begin
                p1_ca_r <= ca[9:2];
            end
            if ((bs_r == BS_TAIL) && !burst_ap_n_r) begin
                bank_act_r[burst_bank_r] <= 1'b0;
            end
            if (pre_go_s) begin
                bank_act_r[ca[9:6]] <= 1'b0;
            end
            if (act_go_s) begin
                bank_act_r[p1_bank_s] <= 1'b1;
                bank_row_r[p1_bank_s] <= {ca[11:0], p1_ca_r[5:2]};
            end
            if (burst_go_s) begin
                burst_rd_r   <= (ph_r == PH_RD);
                burst_bank_r <= p1_bank_s;
                burst_row_r  <= bank_row_r[p1_bank_s];
                burst_col_r  <= (ph_r == PH_RD) ? ca[7:2] : ca[6:1];
                burst_ap_n_r <= (ph_r == PH_RD) ? ca[9] : ca[8];
                dly_r        <= (ph_r == PH_RD) ? RD_LOAD : WR_LOAD;
                beat_r       <= 4'd0;
            end else if ((bs_r == BS_WAIT) && (dly_r != 8'd0)) begin
                dly_r <= dly_r - 8'd1;
            end
            if (emit_s) begin
                beat_r     <= beat_r + 4'd1;
                mem_addr_r <= {burst_bank_r, burst_row_r, burst_col_r, beat_r};
            end
            if (emit_s && !burst_rd_r) begin
                mem_wr_data_r <= dq_in;
            end
            mem_rd_en_r    <= emit_s & burst_rd_r;
            mem_wr_en_r    <= emit_s & ~burst_rd_r;
            dq_oe_r        <= mem_rd_en_r;
            protocol_err_r <= (err_code_s != ERR_NONE);
            err_code_r     <= err_code_s;
        end
    end

    // Read data arrives one cycle after mem_rd_en, in the same cycle it must be on dq.
    assign dq_out       = dq_oe_r ? mem_rd_data : {DATA_WIDTH{1'b0}};
    assign dq_oe        = dq_oe_r;
    assign mem_rd_en    = mem_rd_en_r;
    assign mem_wr_en    = mem_wr_en_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wr_data  = mem_wr_data_r;
    assign protocol_err = protocol_err_r;
    assign err_code     = err_code_r;

endmodule

// File: tb/tb_ddr5_device_responder.sv
// Bench for ddr5_device_responder: command table plus hand sequences, with a
// cycle-stamped scoreboard for read/write beats and error pulses.
module tb_ddr5_device_responder;

    localparam int DW     = 16;
    localparam int RL     = 11;
    localparam int WL     = 8;
    localparam int K_ACT  = 0;
    localparam int K_RD   = 1;
    localparam int K_WR   = 2;
    localparam int K_PRE  = 3;
    localparam int K_REF  = 4;
    localparam int K_ILL  = 5;

    typedef struct {
        int          cyc;
        logic [29:0] addr;
        logic [15:0] data;
    } ev_t;

    typedef struct {
        int          kind;
        logic [3:0]  bb;
        logic [15:0] row;
        logic [5:0]  col;
        logic        ap_n;
        logic        bad_cs;
        logic [2:0]  exp_err;
        int          gap;
        int          n_en;
        int          n_dq;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          cs_n;
    logic [13:0]   ca;
    logic [DW-1:0] dq_in;
    logic [DW-1:0] dq_out;
    logic          dq_oe;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [29:0]   mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic          protocol_err;
    logic [2:0]    err_code;

    int  cyc = 0;
    int  wr_t0 = -1000;
    int  n_tests = 0;
    int  n_fail = 0;
    ev_t rd_q[$];
    ev_t dq_q[$];
    ev_t wr_q[$];
    ev_t err_q[$];
    ev_t mon_e;
    vec_t tbl[15];

    ddr5_device_responder #(.DATA_WIDTH(DW), .RL(RL), .WL(WL)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .ca(ca), .dq_in(dq_in),
        .dq_out(dq_out), .dq_oe(dq_oe), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .protocol_err(protocol_err), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Backing store returns the beat index one cycle after a read request.
    always @(posedge clk) mem_rd_data <= mem_rd_en ? {12'd0, mem_addr[3:0]} : 16'hDEAD;

    // Write data for beat i is 0xA000+i, sampled at the edge of that beat.
    initial begin
        dq_in = 16'd0;
        forever begin
            @(negedge clk);
            dq_in = 16'hA000 + 16'(cyc + 1 - wr_t0 - WL);
        end
    end

    task automatic chk(input bit ok, input string nm, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    function automatic vec_t mk(int kind, logic [3:0] bb, logic [15:0] row, logic [5:0] col,
                                logic ap_n, logic bad_cs, logic [2:0] exp_err, int gap);
        vec_t v;
        v.kind = kind;   v.bb = bb;         v.row = row;          v.col = col;
        v.ap_n = ap_n;   v.bad_cs = bad_cs; v.exp_err = exp_err;  v.gap = gap;
        v.n_en = 16;     v.n_dq = 16;
        return v;
    endfunction

    // Drive one command, push its expected effects, then idle for v.gap cycles.
    task automatic issue(input vec_t v, output int t);
        logic [13:0] p1;
        logic [13:0] p2;
        bit          two;
        p2  = 14'd0;
        two = (v.kind == K_ACT) || (v.kind == K_RD) || (v.kind == K_WR);
        case (v.kind)
            K_ACT: begin p1 = {4'd0, v.bb, v.row[3:0], 2'b00};  p2 = {2'd0, v.row[15:4]}; end
            K_RD:  begin p1 = {4'd0, v.bb, 1'b0, 5'b11101};     p2 = {4'd0, v.ap_n, 1'b0, v.col, 2'b00}; end
            K_WR:  begin p1 = {4'd0, v.bb, 1'b0, 5'b01101};     p2 = {5'd0, v.ap_n, 1'b0, v.col, 1'b0}; end
            K_PRE: p1 = {4'd0, v.bb, 6'b011011};
            K_REF: p1 = {9'd0, 5'b10011};
            default: p1 = {9'd0, 5'b00001};
        endcase
        cs_n = 1'b0;
        ca   = p1;
        if (two) begin
            @(negedge clk);
            cs_n = ~v.bad_cs;
            ca   = p2;
        end
        t = cyc + 1;
        if (v.exp_err != 3'd0) begin
            err_q.push_back('{t, 30'd0, 16'(v.exp_err)});
        end else if (v.kind == K_RD) begin
            for (int i = 0; i < v.n_en; i++) rd_q.push_back('{t + RL - 1 + i, {v.bb, v.row, v.col, 4'(i)}, 16'd0});
            for (int i = 0; i < v.n_dq; i++) dq_q.push_back('{t + RL + i, 30'd0, 16'(i)});
        end else if (v.kind == K_WR) begin
            wr_t0 = t;
            for (int i = 0; i < 16; i++) wr_q.push_back('{t + WL + i, {v.bb, v.row, v.col, 4'(i)}, 16'hA000 + 16'(i)});
        end
        @(negedge clk);
        cs_n = 1'b1;
        ca   = 14'd0;
        repeat (v.gap) @(negedge clk);
    endtask

    // Scoreboard: every DUT event must match the head of its queue in cycle and content.
    always @(posedge clk) begin
        #2;
        if (mem_rd_en) begin
            if (rd_q.size() == 0) chk(1'b0, "rd_en_unexpected", 64'(mem_addr), 64'd0);
            else begin
                mon_e = rd_q.pop_front();
                chk(mon_e.cyc == cyc, "rd_en_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk(mem_addr == mon_e.addr, "rd_addr", 64'(mem_addr), 64'(mon_e.addr));
            end
        end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
            mon_e = rd_q.pop_front();
            chk(1'b0, "rd_en_missing", 64'(cyc), 64'(mon_e.cyc));
        end
        if (dq_oe) begin
            if (dq_q.size() == 0) chk(1'b0, "dq_oe_unexpected", 64'(dq_out), 64'd0);
            else begin
                mon_e = dq_q.pop_front();
                chk(mon_e.cyc == cyc, "dq_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk(dq_out == mon_e.data, "dq_data", 64'(dq_out), 64'(mon_e.data));
            end
        end else begin
            chk(dq_out == 16'd0, "dq_out_idle", 64'(dq_out), 64'd0);
            if (dq_q.size() != 0 && dq_q[0].cyc <= cyc) begin
                mon_e = dq_q.pop_front();
                chk(1'b0, "dq_oe_missing", 64'(cyc), 64'(mon_e.cyc));
            end
        end
        if (mem_wr_en) begin
            if (wr_q.size() == 0) chk(1'b0, "wr_en_unexpected", 64'(mem_addr), 64'd0);
            else begin
                mon_e = wr_q.pop_front();
                chk(mon_e.cyc == cyc, "wr_en_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk(mem_addr == mon_e.addr, "wr_addr", 64'(mem_addr), 64'(mon_e.addr));
                chk(mem_wr_data == mon_e.data, "wr_data", 64'(mem_wr_data), 64'(mon_e.data));
            end
        end else if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
            mon_e = wr_q.pop_front();
            chk(1'b0, "wr_en_missing", 64'(cyc), 64'(mon_e.cyc));
        end
        if (protocol_err) begin
            if (err_q.size() == 0) chk(1'b0, "err_unexpected", 64'(err_code), 64'd0);
            else begin
                mon_e = err_q.pop_front();
                chk(mon_e.cyc == cyc, "err_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk(16'(err_code) == mon_e.data, "err_code", 64'(err_code), 64'(mon_e.data));
            end
        end else if (err_q.size() != 0 && err_q[0].cyc <= cyc) begin
            mon_e = err_q.pop_front();
            chk(1'b0, "err_missing", 64'(cyc), 64'(mon_e.cyc));
        end
    end

    initial begin
        int   t;
        vec_t v;
        tbl[0]  = mk(K_ACT, 4'h6, 16'h1234, 6'd0, 1'b1, 1'b0, 3'd0, 2);
        tbl[1]  = mk(K_RD,  4'h6, 16'h1234, 6'd5, 1'b1, 1'b0, 3'd0, 40);
        tbl[2]  = mk(K_ACT, 4'h6, 16'h0055, 6'd0, 1'b1, 1'b0, 3'd3, 2);
        tbl[3]  = mk(K_REF, 4'h0, 16'h0000, 6'd0, 1'b1, 1'b0, 3'd4, 2);
        tbl[4]  = mk(K_RD,  4'h3, 16'h0000, 6'd1, 1'b1, 1'b0, 3'd2, 2);
        tbl[5]  = mk(K_ACT, 4'h3, 16'hBEEF, 6'd0, 1'b1, 1'b1, 3'd6, 2);
        tbl[6]  = mk(K_RD,  4'h3, 16'h0000, 6'd1, 1'b1, 1'b0, 3'd2, 2);
        tbl[7]  = mk(K_ILL, 4'h0, 16'h0000, 6'd0, 1'b1, 1'b0, 3'd1, 2);
        tbl[8]  = mk(K_ACT, 4'h3, 16'hBEEF, 6'd0, 1'b1, 1'b0, 3'd0, 2);
        tbl[9]  = mk(K_WR,  4'h3, 16'hBEEF, 6'd0, 1'b0, 1'b0, 3'd0, 23);
        tbl[10] = mk(K_RD,  4'h3, 16'hBEEF, 6'd4, 1'b1, 1'b0, 3'd2, 2);
        tbl[11] = mk(K_PRE, 4'h6, 16'h0000, 6'd0, 1'b1, 1'b0, 3'd0, 2);
        tbl[12] = mk(K_REF, 4'h0, 16'h0000, 6'd0, 1'b1, 1'b0, 3'd0, 2);
        tbl[13] = mk(K_PRE, 4'h6, 16'h0000, 6'd0, 1'b1, 1'b0, 3'd0, 2);
        tbl[14] = mk(K_WR,  4'h6, 16'h0000, 6'd0, 1'b1, 1'b0, 3'd2, 2);

        rst_n = 1'b0;
        cs_n  = 1'b1;
        ca    = 14'd0;
        repeat (4) @(negedge clk);
        chk(dq_oe == 1'b0,        "rst_dq_oe",        64'(dq_oe),        64'd0);
        chk(dq_out == 16'd0,      "rst_dq_out",       64'(dq_out),       64'd0);
        chk(mem_rd_en == 1'b0,    "rst_mem_rd_en",    64'(mem_rd_en),    64'd0);
        chk(mem_wr_en == 1'b0,    "rst_mem_wr_en",    64'(mem_wr_en),    64'd0);
        chk(mem_addr == 30'd0,    "rst_mem_addr",     64'(mem_addr),     64'd0);
        chk(mem_wr_data == 16'd0, "rst_mem_wr_data",  64'(mem_wr_data),  64'd0);
        chk(protocol_err == 1'b0, "rst_protocol_err", 64'(protocol_err), 64'd0);
        chk(err_code == 3'd0,     "rst_err_code",     64'(err_code),     64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) issue(tbl[i], t);

        // Second read three cycles after the first is rejected as busy.
        issue(mk(K_ACT, 4'h0, 16'h00A5, 6'd0, 1'b1, 1'b0, 3'd0, 2), t);
        issue(mk(K_RD,  4'h0, 16'h00A5, 6'd7, 1'b1, 1'b0, 3'd0, 1), t);
        issue(mk(K_RD,  4'h0, 16'h00A5, 6'd9, 1'b1, 1'b0, 3'd5, 40), t);

        // PRE mid-write closes the bank at once; the burst keeps its latched row.
        issue(mk(K_WR,  4'h0, 16'h00A5, 6'd63, 1'b1, 1'b0, 3'd0, 10), t);
        issue(mk(K_PRE, 4'h0, 16'h0000, 6'd0,  1'b1, 1'b0, 3'd0, 30), t);
        issue(mk(K_RD,  4'h0, 16'h00A5, 6'd0,  1'b1, 1'b0, 3'd2, 2), t);

        // Reset during read beat 7 aborts the burst and closes all banks.
        issue(mk(K_ACT, 4'h5, 16'h0F0F, 6'd0, 1'b1, 1'b0, 3'd0, 2), t);
        v = mk(K_RD, 4'h5, 16'h0F0F, 6'd2, 1'b1, 1'b0, 3'd0, 0);
        v.n_en = 9;
        v.n_dq = 8;
        issue(v, t);
        while (cyc < t + RL + 7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk(dq_oe == 1'b0,     "rst_mid_dq_oe",     64'(dq_oe),     64'd0);
        chk(mem_rd_en == 1'b0, "rst_mid_mem_rd_en", 64'(mem_rd_en), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(mk(K_RD, 4'h5, 16'h0F0F, 6'd2, 1'b1, 1'b0, 3'd2, 40), t);

        chk(rd_q.size() == 0,  "rd_q_drained",  64'(rd_q.size()),  64'd0);
        chk(dq_q.size() == 0,  "dq_q_drained",  64'(dq_q.size()),  64'd0);
        chk(wr_q.size() == 0,  "wr_q_drained",  64'(wr_q.size()),  64'd0);
        chk(err_q.size() == 0, "err_q_drained", 64'(err_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
